// File: rtl/z80_daisy_irq.sv
// Z80 mode-2 daisy-chain interrupt unit: up to four prioritised channels, INT_n/IEI/IEO and vector drive.
// Latency: one register stage; requests, acknowledges and RETIs take effect at the enabled edge that samples them.
// Backpressure: none; the CPU paces the unit through SPM1 and RETI, and I_CLKEN freezes all state.
module z80_daisy_irq #(
    parameter int NCH = 4
) (
    input  logic           I_CLK,
    input  logic           I_RESET,
    input  logic           I_CLKEN,
    input  logic           I_M1_n,
    input  logic           I_SPM1,
    input  logic           I_RETI,
    input  logic           I_IEI,
    input  logic [NCH-1:0] I_REQ,
    input  logic [7:0]     I_VBASE,
    output logic           O_INT_n,
    output logic           O_IEO,
    output logic [7:0]     O_D,
    output logic           O_DOE
);

    logic [NCH-1:0] ip;
    logic [NCH-1:0] ius;
    logic           spm1_r;
    logic           ack_valid;
    logic [1:0]     ack_ch;

    logic [NCH-1:0] elig;
    logic           any_elig;
    logic           ack_fire;
    logic           reti_fire;
    logic [1:0]     sel;
    logic [1:0]     reti_k;
    logic [NCH-1:0] ip_nxt;
    logic [NCH-1:0] ius_nxt;

    // The low vector bits come from the channel number, not from the base.
    logic unused_vbase;
    assign unused_vbase = ^I_VBASE[2:0];

    // Eligibility: pending and not blocked by itself or any higher-priority in-service channel.
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        elig    = '0;
        for (int i = 0; i < NCH; i++) begin
            blocked = blocked | ius[i];
            elig[i] = ip[i] & ~blocked;
        end
    end

    assign any_elig = |elig;

    // Lowest-index eligible channel and lowest-index in-service channel.
    always_comb begin
        sel    = 2'd0;
        reti_k = 2'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig[i]) sel = 2'(i);
            if (ius[i])  reti_k = 2'(i);
        end
    end

    assign ack_fire  = I_SPM1 & ~spm1_r & I_IEI & any_elig;
    assign reti_fire = I_RETI & I_IEI & (|ius);

    // Next pending/in-service state, all evaluated from the pre-update registers.
    always_comb begin
        ip_nxt  = ip;
        ius_nxt = ius;
        if (ack_fire) begin
            ip_nxt[sel]  = 1'b0;
            ius_nxt[sel] = 1'b1;
        end
        // A new request on the acknowledged channel is kept.
        ip_nxt = ip_nxt | I_REQ;
        // The RETI clear is applied last so it wins on a shared bit.
        if (reti_fire) begin
            ius_nxt[reti_k] = 1'b0;
        end
    end

    // Register update, qualified by the CPU clock enable.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            ip        <= '0;
            ius       <= '0;
            spm1_r    <= 1'b0;
            ack_valid <= 1'b0;
            ack_ch    <= 2'd0;
        end else if (I_CLKEN) begin
            ip     <= ip_nxt;
            ius    <= ius_nxt;
            spm1_r <= I_SPM1;
            if (ack_fire) begin
                ack_valid <= 1'b1;
                ack_ch    <= sel;
            end else if (!I_SPM1) begin
                ack_valid <= 1'b0;
            end
        end
    end

    // Bus-facing outputs: chain and request from registers, vector drive gated by the live SPM1 level.
    always_comb begin
        O_INT_n = ~(I_IEI & any_elig);
        O_IEO   = I_IEI & ~(|ius) & ~(any_elig & ~I_M1_n);
        O_DOE   = ack_valid & I_SPM1;
        O_D     = O_DOE ? {I_VBASE[7:3], ack_ch, 1'b0} : 8'h00;
    end

endmodule

// File: tb/tb_z80_daisy_irq.sv
module tb_z80_daisy_irq;

    localparam int NCH = 4;

    logic           clk;
    logic           rst;
    logic           clken;
    logic           m1_n;
    logic           spm1;
    logic           reti;
    logic           iei;
    logic [NCH-1:0] req;
    logic [7:0]     vbase;
    logic           int_n;
    logic           ieo;
    logic [7:0]     d;
    logic           doe;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    z80_daisy_irq #(.NCH(NCH)) dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .I_CLKEN (clken),
        .I_M1_n  (m1_n),
        .I_SPM1  (spm1),
        .I_RETI  (reti),
        .I_IEI   (iei),
        .I_REQ   (req),
        .I_VBASE (vbase),
        .O_INT_n (int_n),
        .O_IEO   (ieo),
        .O_D     (d),
        .O_DOE   (doe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_pend [NCH];
    bit m_serv [NCH];
    bit m_spm1_seen;
    bit m_on_bus;
    int m_vec_ch;

    function automatic int first_eligible();
        for (int c = 0; c < NCH; c++) begin
            bit ok;
            ok = m_pend[c];
            for (int h = 0; h <= c; h++) if (m_serv[h]) ok = 0;
            if (ok) return c;
        end
        return -1;
    endfunction

    function automatic int first_in_service();
        for (int c = 0; c < NCH; c++) if (m_serv[c]) return c;
        return -1;
    endfunction

    function automatic logic [NCH-1:0] pack(input bit a [NCH]);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = a[c];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 0;
                m_serv[c] = 0;
            end
            m_spm1_seen = 0;
            m_on_bus    = 0;
            m_vec_ch    = 0;
        end else if (clken) begin
            int  e;
            int  s;
            bit  np [NCH];
            bit  ns [NCH];
            e = first_eligible();
            s = first_in_service();
            np = m_pend;
            ns = m_serv;
            if (spm1 && !m_spm1_seen && iei && e >= 0) begin
                np[e] = 0;
                ns[e] = 1;
                m_on_bus = 1;
                m_vec_ch = e;
            end else if (!spm1) begin
                m_on_bus = 0;
            end
            if (reti && iei && s >= 0) ns[s] = 0;
            for (int c = 0; c < NCH; c++) if (req[c]) np[c] = 1;
            m_pend = np;
            m_serv = ns;
            m_spm1_seen = spm1;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit  e_int_n;
            bit  e_ieo;
            bit  e_doe;
            logic [7:0] e_d;
            e_int_n = !(iei && first_eligible() >= 0);
            e_ieo   = iei && first_in_service() < 0 && !(first_eligible() >= 0 && !m1_n);
            e_doe   = m_on_bus && spm1;
            e_d     = e_doe ? ((vbase & 8'hF8) | 8'(m_vec_ch * 2)) : 8'h00;
            check("cyc_int_n", {7'd0, int_n}, {7'd0, e_int_n});
            check("cyc_ieo",   {7'd0, ieo},   {7'd0, e_ieo});
            check("cyc_doe",   {7'd0, doe},   {7'd0, e_doe});
            check("cyc_d",     d,             e_d);
            check("cyc_ip",    {4'd0, dut.ip},  {4'd0, pack(m_pend)});
            check("cyc_ius",   {4'd0, dut.ius}, {4'd0, pack(m_serv)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [NCH-1:0] r);
        req = r;
        step();
        req = '0;
    endtask

    task automatic do_ack();
        m1_n = 1'b0;
        spm1 = 1'b1;
        step();
    endtask

    task automatic end_ack();
        spm1 = 1'b0;
        m1_n = 1'b1;
        #1;
        step();
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        step();
        reti = 1'b0;
    endtask

    task automatic c1(input string name, input logic act, input logic exp);
        check(name, {7'd0, act}, {7'd0, exp});
    endtask

    initial begin
        rst = 1'b1; clken = 1'b1; m1_n = 1'b1; spm1 = 1'b0; reti = 1'b0;
        iei = 1'b1; req = '0; vbase = 8'h40;
        step();
        step();
        rst = 1'b0;
        chk_en = 1;
        c1("rst_int_n", int_n, 1'b1);
        c1("rst_doe", doe, 1'b0);
        check("rst_d", d, 8'h00);
        c1("rst_ieo", ieo, 1'b1);

        // Basic request / acknowledge / RETI
        pulse_req(4'b0100);
        c1("req_int_n", int_n, 1'b0);
        do_ack();
        c1("ack_doe", doe, 1'b1);
        check("ack_d", d, 8'h44);
        c1("ack_int_n", int_n, 1'b1);
        c1("ack_ieo", ieo, 1'b0);
        check("ack_ius", {4'd0, dut.ius}, 8'h04);
        end_ack();
        c1("post_ack_doe", doe, 1'b0);
        pulse_reti();
        c1("reti_ieo", ieo, 1'b1);

        // Nesting
        pulse_req(4'b0100);
        do_ack();
        check("nest_d2", d, 8'h44);
        end_ack();
        pulse_req(4'b0001);
        c1("nest_int_n", int_n, 1'b0);
        do_ack();
        check("nest_d0", d, 8'h40);
        check("nest_ius", {4'd0, dut.ius}, 8'h05);
        end_ack();
        pulse_reti();
        check("nest_reti1", {4'd0, dut.ius}, 8'h04);
        pulse_reti();
        check("nest_reti2", {4'd0, dut.ius}, 8'h00);

        // Blocking by a higher-priority in-service channel
        pulse_req(4'b0010);
        do_ack();
        check("blk_d1", d, 8'h42);
        end_ack();
        pulse_req(4'b1000);
        c1("blk_int_n", int_n, 1'b1);
        pulse_reti();
        c1("blk_unblock", int_n, 1'b0);
        do_ack();
        check("blk_d3", d, 8'h46);
        end_ack();

        // Chain: IEI low with ius[3] held
        iei = 1'b0;
        #1;
        pulse_req(4'b0010);
        c1("chn_int_n", int_n, 1'b1);
        c1("chn_ieo", ieo, 1'b0);
        do_ack();
        c1("chn_doe", doe, 1'b0);
        check("chn_d", d, 8'h00);
        end_ack();
        pulse_reti();
        check("chn_ius", {4'd0, dut.ius}, 8'h08);
        iei = 1'b1;
        #1;
        c1("chn_iei_int_n", int_n, 1'b0);
        pulse_reti();

        // Freeze: pending ip[1], M1 cycling
        c1("frz_m1hi", ieo, 1'b1);
        m1_n = 1'b0;
        #1;
        c1("frz_m1lo", ieo, 1'b0);
        m1_n = 1'b1;
        #1;
        c1("frz_m1hi2", ieo, 1'b1);
        do_ack();
        check("frz_d1", d, 8'h42);
        end_ack();
        pulse_reti();

        // Request together with acknowledge of the same channel
        pulse_req(4'b0001);
        req = 4'b0001;
        do_ack();
        req = '0;
        check("same_ius", {4'd0, dut.ius}, 8'h01);
        check("same_ip", {4'd0, dut.ip}, 8'h01);
        check("same_d", d, 8'h40);
        end_ack();
        pulse_reti();
        do_ack();
        end_ack();
        pulse_reti();

        // Clock enable low masks a request
        clken = 1'b0;
        pulse_req(4'b0100);
        clken = 1'b1;
        check("clken_ip", {4'd0, dut.ip}, 8'h00);
        c1("clken_int_n", int_n, 1'b1);

        // Reset during acknowledge
        pulse_req(4'b0100);
        do_ack();
        c1("rsta_doe", doe, 1'b1);
        rst = 1'b1;
        step();
        c1("rsta_doe_after", doe, 1'b0);
        c1("rsta_int_n", int_n, 1'b1);
        rst = 1'b0;
        end_ack();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
